// File: rtl/conv_weight_receiver_if.sv
// Stage/weight bus between the conv layer control, the weight cache output and the
// kernel receiver.
interface conv_weight_receiver_if #(
   parameter int WIDTH       = 32,
   parameter int KERNEL_SIZE = 3
);
   logic [2:0]                               current_state;
   logic [WIDTH-1:0]                         i_weight;
   logic [WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] o_kernel;
   logic                                     o_kernel_update;
   logic                                     o_filling;
   logic [3:0]                               o_wr_idx;
   logic [7:0]                               o_set_cnt;

   modport master (
      output current_state, i_weight,
      input  o_kernel, o_kernel_update, o_filling, o_wr_idx, o_set_cnt
   );

   modport slave (
      input  current_state, i_weight,
      output o_kernel, o_kernel_update, o_filling, o_wr_idx, o_set_cnt
   );
endinterface

// File: rtl/conv_weight_receiver.sv
// Assembles the weight words streamed during STAGE_SHIFT into a shadow kernel and
// commits each complete kernel atomically to the active bank feeding the PE array.
module conv_weight_receiver #(
   parameter int         WIDTH         = 32,
   parameter int         KERNEL_SIZE   = 3,
   parameter logic [2:0] STAGE_INIT    = 3'd0,
   parameter logic [2:0] STAGE_PRELOAD = 3'd1,
   parameter logic [2:0] STAGE_SHIFT   = 3'd2,
   parameter logic [2:0] STAGE_LOAD    = 3'd3
) (
   input logic                   clk,
   input logic                   rst_n,
   conv_weight_receiver_if.slave bus
);
   localparam int         NWORDS   = KERNEL_SIZE * KERNEL_SIZE;
   localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t                             state_r;
   logic                               shift_d_r;
   logic [3:0]                         wr_idx_r;
   logic [NWORDS-2:0][WIDTH-1:0]       shadow_r;
   logic [NWORDS-1:0][WIDTH-1:0]       kernel_r;
   logic                               update_r;
   logic                               filling_r;
   logic [7:0]                         set_cnt_r;
   logic                               abort_s;

   assign abort_s = (bus.current_state == STAGE_LOAD) || (bus.current_state == STAGE_INIT);

   // Capture FSM: the last slot of a set is never buffered, it goes straight into the
   // active bank together with the shadow words so the kernel changes in one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         shift_d_r <= 1'b0;
         wr_idx_r  <= 4'd0;
         shadow_r  <= '0;
         kernel_r  <= '0;
         update_r  <= 1'b0;
         filling_r <= 1'b0;
         set_cnt_r <= 8'd0;
      end else begin
         shift_d_r <= (bus.current_state == STAGE_SHIFT);
         update_r  <= 1'b0;
         if (shift_d_r) begin
            case (state_r)
               IDLE: begin
                  shadow_r[0] <= bus.i_weight;
                  wr_idx_r    <= 4'd1;
                  state_r     <= FILL;
                  filling_r   <= 1'b1;
               end
               FILL: begin
                  if (wr_idx_r == LAST_IDX) begin
                     for (int k = 0; k < NWORDS - 1; k++) begin
                        kernel_r[k] <= shadow_r[k];
                     end
                     kernel_r[NWORDS-1] <= bus.i_weight;
                     update_r           <= 1'b1;
                     set_cnt_r          <= set_cnt_r + 8'd1;
                     wr_idx_r           <= 4'd0;
                     state_r            <= IDLE;
                     filling_r          <= 1'b0;
                  end else begin
                     for (int k = 0; k < NWORDS - 1; k++) begin
                        if (wr_idx_r == 4'(k)) begin
                           shadow_r[k] <= bus.i_weight;
                        end
                     end
                     wr_idx_r <= wr_idx_r + 4'd1;
                  end
               end
               default: begin
                  wr_idx_r  <= 4'd0;
                  state_r   <= IDLE;
                  filling_r <= 1'b0;
               end
            endcase
         end
         // LOAD/INIT override the slot pointer after any same-edge capture or commit.
         if (abort_s) begin
            wr_idx_r  <= 4'd0;
            state_r   <= IDLE;
            filling_r <= 1'b0;
         end
         if (bus.current_state == STAGE_INIT) begin
            set_cnt_r <= 8'd0;
         end
      end
   end

   assign bus.o_kernel        = kernel_r;
   assign bus.o_kernel_update = update_r;
   assign bus.o_filling       = filling_r;
   assign bus.o_wr_idx        = wr_idx_r;
   assign bus.o_set_cnt       = set_cnt_r;
endmodule

// File: tb/tb_conv_weight_receiver.sv
// Directed bench for conv_weight_receiver: a cache-latency driver model feeds a
// scoreboard of expected kernels that is drained on every update pulse.
module tb_conv_weight_receiver;
   localparam logic [2:0] ST_INIT    = 3'd0;
   localparam logic [2:0] ST_PRELOAD = 3'd1;
   localparam logic [2:0] ST_SHIFT   = 3'd2;
   localparam logic [2:0] ST_LOAD    = 3'd3;

   typedef logic [8:0][31:0] kern_t;

   logic clk;
   logic rst_n;
   conv_weight_receiver_if #(.WIDTH(32), .KERNEL_SIZE(3)) bus ();

   conv_weight_receiver #(.WIDTH(32), .KERNEL_SIZE(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   kern_t       sb_q[$];
   kern_t       m_buf;
   kern_t       exp_active;
   int          m_idx;
   logic [7:0]  m_cnt;
   bit          pend_valid;
   logic [31:0] pend_word;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_kernel(input string tag);
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("%s_w%0d", tag, k), bus.o_kernel[k*32 +: 32], exp_active[k]);
      end
   endtask

   // One cycle: st is this cycle's stage; word is what the cache fetches now and
   // presents on i_weight next cycle.
   task automatic tick_x(input logic [2:0] st, input logic [31:0] word,
                         input bit use_raw, input logic [31:0] raw);
      bit commit_now;
      commit_now = 1'b0;
      @(negedge clk);
      bus.current_state = st;
      bus.i_weight      = use_raw ? raw : (pend_valid ? pend_word : 32'h0);
      if (pend_valid) begin
         m_buf[m_idx] = pend_word;
         m_idx++;
         if (m_idx == 9) begin
            sb_q.push_back(m_buf);
            m_idx      = 0;
            m_cnt      = m_cnt + 8'd1;
            commit_now = 1'b1;
         end
      end
      if (st == ST_LOAD || st == ST_INIT) m_idx = 0;
      if (st == ST_INIT) m_cnt = 8'd0;
      pend_valid = (st == ST_SHIFT);
      pend_word  = word;
      @(posedge clk);
      #1;
      chk("update", 32'(bus.o_kernel_update), 32'(commit_now));
      if (bus.o_kernel_update) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) exp_active = sb_q.pop_front();
      end
      chk_kernel("kernel");
      chk("wr_idx", 32'(bus.o_wr_idx), 32'(m_idx));
      chk("set_cnt", 32'(bus.o_set_cnt), 32'(m_cnt));
      chk("filling", 32'(bus.o_filling), 32'(m_idx != 0));
   endtask

   task automatic tick(input logic [2:0] st, input logic [31:0] word);
      tick_x(st, word, 1'b0, 32'h0);
   endtask

   task automatic shift_words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) tick(ST_SHIFT, base + 32'(i));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_update"}, 32'(bus.o_kernel_update), 32'd0);
      chk({tag, "_filling"}, 32'(bus.o_filling), 32'd0);
      chk({tag, "_wr_idx"}, 32'(bus.o_wr_idx), 32'd0);
      chk({tag, "_set_cnt"}, 32'(bus.o_set_cnt), 32'd0);
      chk_kernel(tag);
   endtask

   initial begin
      m_idx = 0; m_cnt = 8'd0; m_buf = '0; exp_active = '0;
      pend_valid = 1'b0; pend_word = 32'h0;
      rst_n = 1'b0;
      bus.current_state = ST_PRELOAD;
      bus.i_weight = 32'h0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single kernel 0x11..0x19.
      shift_words(32'h11, 9);
      tick(ST_PRELOAD, 32'h0);
      chk("t1_w0", bus.o_kernel[31:0], 32'h11);
      chk("t1_w8", bus.o_kernel[8*32 +: 32], 32'h19);
      chk("t1_cnt", 32'(bus.o_set_cnt), 32'd1);
      tick(ST_PRELOAD, 32'h0);

      // Partial set aborted by LOAD, then a full set.
      shift_words(32'hA0, 5);
      tick(ST_PRELOAD, 32'h0);
      chk("t2_idx5", 32'(bus.o_wr_idx), 32'd5);
      tick(ST_LOAD, 32'h0);
      chk("t2_idx0", 32'(bus.o_wr_idx), 32'd0);
      shift_words(32'hB0, 9);
      tick(ST_PRELOAD, 32'h0);
      chk("t2_w0", bus.o_kernel[31:0], 32'hB0);
      chk("t2_w8", bus.o_kernel[8*32 +: 32], 32'hB8);

      // 18 back-to-back words: two commits.
      shift_words(32'h1, 18);
      tick(ST_PRELOAD, 32'h0);
      chk("t3_w0", bus.o_kernel[31:0], 32'd10);
      chk("t3_w8", bus.o_kernel[8*32 +: 32], 32'd18);
      chk("t3_cnt", 32'(bus.o_set_cnt), 32'd4);

      // 9th word arrives in the LOAD cycle.
      shift_words(32'hC0, 9);
      tick(ST_LOAD, 32'h0);
      chk("t4_cnt", 32'(bus.o_set_cnt), 32'd5);
      chk("t4_w8", bus.o_kernel[8*32 +: 32], 32'hC8);
      tick(ST_PRELOAD, 32'h0);

      // Asynchronous reset mid-fill.
      shift_words(32'hD0, 4);
      tick(ST_PRELOAD, 32'h0);
      chk("t5_idx4", 32'(bus.o_wr_idx), 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      m_idx = 0; m_cnt = 8'd0; exp_active = '0; pend_valid = 1'b0;
      sb_q.delete();
      chk_all_zero("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      shift_words(32'hE0, 9);
      tick(ST_PRELOAD, 32'h0);
      chk("t5_w0", bus.o_kernel[31:0], 32'hE0);
      chk("t5_cnt", 32'(bus.o_set_cnt), 32'd1);

      // Three sets total, then INIT; PRELOAD garbage is ignored.
      shift_words(32'hF0, 9);
      shift_words(32'h300, 9);
      tick(ST_PRELOAD, 32'h0);
      chk("t6_cnt3", 32'(bus.o_set_cnt), 32'd3);
      tick(ST_INIT, 32'h0);
      chk("t6_cnt0", 32'(bus.o_set_cnt), 32'd0);
      chk("t6_w0", bus.o_kernel[31:0], 32'h300);
      tick_x(ST_PRELOAD, 32'h0, 1'b1, 32'hDEAD);
      tick_x(ST_PRELOAD, 32'h0, 1'b1, 32'hDEAD);
      chk("t6_idx", 32'(bus.o_wr_idx), 32'd0);
      chk("t6_w8", bus.o_kernel[8*32 +: 32], 32'h308);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/conv_weight_receiver.md
Name: conv_weight_receiver

Overview:
- Consumer-side end of the convolution weight stream.
- Captures the registered weight words that the weight cache emits during STAGE_SHIFT, assembles them into a KERNEL_SIZE x KERNEL_SIZE kernel in a shadow bank, and commits each complete kernel atomically to an active bank.
- The active bank drives the PE array weight inputs.
- Shares the conv layer's stage encoding and follows the same current_state sequencing as the cache.

Parameters:
- WIDTH, 32, bits per weight word
- KERNEL_SIZE, 3, kernel edge; kernel = KERNEL_SIZE*KERNEL_SIZE words (9)
- STAGE_INIT, 3'd0, stage code
- STAGE_PRELOAD, 3'd1, stage code
- STAGE_SHIFT, 3'd2, stage code
- STAGE_LOAD, 3'd3, stage code

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- current_state  input  3  conv layer stage, same bus that drives the weight cache
- i_weight  input  WIDTH  registered weight word from the cache
- o_kernel  output  WIDTH*KERNEL_SIZE*KERNEL_SIZE  active kernel, flat; word k at bits [k*WIDTH +: WIDTH]
- o_kernel_update  output  1  one-cycle pulse when o_kernel changes
- o_filling  output  1  high while a kernel set is partially captured
- o_wr_idx  output  4  next shadow slot to write (0..8)
- o_set_cnt  output  8  number of kernels committed since reset/INIT, wraps 255->0

Behaviour:
- Reset (async, rst_n low):
  - o_kernel, shadow bank, o_kernel_update, o_filling, o_wr_idx, o_set_cnt and shift_d all go to 0 immediately.
  - Reset mid-fill discards the partial set.
- Capture timing:
  - shift_d <= (current_state == STAGE_SHIFT) each cycle.
  - Because the cache registers its output, the word fetched during a SHIFT cycle is on i_weight the next cycle.
  - i_weight is captured only on edges where shift_d == 1. All other i_weight values, including the zeros the cache emits outside SHIFT, are ignored.
- FSM, two states:
  - IDLE: wr_idx == 0. A capture writes shadow[0], sets wr_idx to 1 and moves to FILL.
  - FILL: each capture writes shadow[wr_idx] and increments wr_idx.
  - Capture at wr_idx == 8 is the commit:
    - o_kernel words 0..7 <= shadow[0..7] and word 8 <= i_weight, all on the same edge.
    - o_kernel_update <= 1 for that cycle only.
    - o_set_cnt increments.
    - wr_idx <= 0; FSM returns to IDLE.
- Commit latency: o_kernel reflects the new set one edge after the 9th word appears on i_weight. It is never partially updated.
- STAGE_LOAD (current_state == 3):
  - Forces wr_idx <= 0 and IDLE, discarding any partial set.
  - The shadow bank and o_kernel are retained.
- STAGE_INIT:
  - Same as LOAD, and also clears o_set_cnt.
  - o_kernel is retained.
- STAGE_PRELOAD and unknown codes (4..7): no effect beyond the shift_d update.
- Simultaneous events:
  - If shift_d == 1 and current_state is LOAD or INIT on the same edge, the capture (and commit, if it is the 9th word) happens first.
  - wr_idx then still ends at 0.
  - A commit on that edge still pulses o_kernel_update and increments o_set_cnt. For INIT the counter result is 0, because the clear wins.
- Continuous SHIFT beyond 9 words: the 10th word starts a new set at shadow[0]. No stall and no error.
- Outputs:
  - o_filling = (FSM == FILL), registered.
  - o_wr_idx = wr_idx.
  - All outputs are registered; there are no combinational input-to-output paths.
- Widths: no arithmetic on weight data. Words are stored verbatim.

Test Plan:
- Reset, then hold SHIFT 9 cycles with the cache driving words 0x11..0x19 one cycle later -> after the 9th word, o_kernel word0 = 0x11 and word8 = 0x19; o_kernel_update high exactly one cycle; o_set_cnt = 1; o_wr_idx = 0.
- SHIFT 5 cycles (words A0..A4), then LOAD, then SHIFT 9 cycles (B0..B8):
  - No update after A4.
  - o_wr_idx goes 5 -> 0 on LOAD.
  - Final o_kernel = B0..B8; o_set_cnt = 1.
- SHIFT for 18 consecutive cycles -> two update pulses 9 cycles apart; o_kernel = words 10..18; o_set_cnt = 2.
- SHIFT 9 cycles immediately followed by LOAD, so the 9th word arrives in the LOAD cycle -> commit still occurs; update pulse; o_set_cnt increments; o_wr_idx = 0.
- Assert rst_n low asynchronously mid-fill at o_wr_idx = 4 -> all outputs 0 without waiting for a clock edge; after release, a full 9-word set commits correctly.
- Commit 3 sets, then INIT -> o_set_cnt = 0 and o_kernel still holds set 3. Also drive i_weight = 0xDEAD during PRELOAD -> not captured; o_wr_idx unchanged.
